// File: rtl/i2s_rx_deserializer.sv
// I2S (Philips) slave receiver. BCK/WS/DIN are oversampled in the clk
// domain and deserialized into parallel left/right samples. BCK is only
// ever treated as data; every flop here runs on clk.
module i2s_rx_deserializer #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bck_i,
    input  logic              ws_i,
    input  logic              din_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    output logic              err_o,
    output logic              locked_o
);

    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t state_q, state_d;

    logic [1:0]        bck_sync, ws_sync, din_sync;
    logic              bck_d, bck_rise;
    logic              ws_r, din_r;      // ws/din delayed to line up with bck_rise
    logic              ws_d;             // WS as seen at the previous rise
    logic [5:0]        bit_cnt;
    logic [5:0]        cnt_inc;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [DATA_W-1:0] left_hold;
    logic              left_ok;
    logic [IW-1:0]     idle_cnt;
    logic              timeout;
    logic              slot_close, slot_full;
    logic              take_left, emit, flag_err;

    // Two-flop synchronizers plus a registered rise detector on BCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync <= '0;
            ws_sync  <= '0;
            din_sync <= '0;
            bck_d    <= 1'b0;
            bck_rise <= 1'b0;
            ws_r     <= 1'b0;
            din_r    <= 1'b0;
        end else begin
            bck_sync <= {bck_sync[0], bck_i};
            ws_sync  <= {ws_sync[0], ws_i};
            din_sync <= {din_sync[0], din_i};
            bck_d    <= bck_sync[1];
            bck_rise <= bck_sync[1] & ~bck_d;
            ws_r     <= ws_sync[1];
            din_r    <= din_sync[1];
        end
    end

    // Idle counter: cleared by every rise, saturates once the timeout fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (bck_rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IW'(TIMEOUT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // A rise in the same cycle always beats the timeout.
    assign timeout = !bck_rise && (idle_cnt == IW'(TIMEOUT - 1));

    assign shift_nxt  = (int'(bit_cnt) < DATA_W) ? {shift[DATA_W-2:0], din_r} : shift;
    assign cnt_inc    = (bit_cnt == 6'd63) ? 6'd63 : bit_cnt + 6'd1;
    assign slot_close = bck_rise && (ws_r != ws_d);
    assign slot_full  = int'(cnt_inc) >= DATA_W;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    // Next state and per-slot decisions; the hunt slot is dropped silently.
    always_comb begin
        state_d   = state_q;
        take_left = 1'b0;
        emit      = 1'b0;
        flag_err  = 1'b0;
        if (slot_close) begin
            case (state_q)
                HUNT: state_d = RUN;
                RUN: begin
                    if (slot_full) begin
                        if (!ws_d)        take_left = 1'b1;
                        else if (left_ok) emit      = 1'b1;
                    end else begin
                        flag_err = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (timeout) begin
            state_d = HUNT;
        end
    end

    // Shift/count datapath and output registers; outputs move only with valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            left_hold <= '0;
            bit_cnt   <= '0;
            ws_d      <= 1'b0;
            left_ok   <= 1'b0;
            left_o    <= '0;
            right_o   <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            locked_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (timeout) begin
                bit_cnt  <= '0;
                left_ok  <= 1'b0;
                locked_o <= 1'b0;
            end else if (bck_rise) begin
                shift   <= shift_nxt;
                bit_cnt <= slot_close ? 6'd0 : cnt_inc;
                ws_d    <= ws_r;
                if (take_left) begin
                    left_hold <= shift_nxt;
                    left_ok   <= 1'b1;
                end
                if (emit) begin
                    left_o   <= left_hold;
                    right_o  <= shift_nxt;
                    valid_o  <= 1'b1;
                    locked_o <= 1'b1;
                    left_ok  <= 1'b0;
                end
                if (flag_err) begin
                    err_o    <= 1'b1;
                    left_ok  <= 1'b0;
                    locked_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: drives a Philips I2S stream at
// BCK = clk/8 and checks pairs, latency, errors, timeout and reset.
module tb_i2s_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst_n, bck, ws, din;
    logic [15:0] left_o, right_o;
    logic        valid_o, err_o, locked_o;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, last_t0 = 0;
    int   err_cnt = 0, vcnt = 0, n_push = 0;

    i2s_rx_deserializer #(.DATA_W(16), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .bck_i(bck), .ws_i(ws), .din_i(din),
        .left_o(left_o), .right_o(right_o), .valid_o(valid_o),
        .err_o(err_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BCK period; called at a negedge. When push is set, the pair that
    // this rise completes is queued with its expected arrival cycle.
    task automatic send_bit(input logic w, input logic b, input bit push,
                            input logic [15:0] el, input logic [15:0] er);
        bck = 1'b0; ws = w; din = b;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        last_t0 = cyc + 1;
        if (push) begin
            sb.push_back('{el, er, last_t0 + 3});
            n_push++;
        end
        repeat (4) @(negedge clk);
    endtask

    // Philips framing: the LSB of a slot is sent with WS already flipped.
    task automatic send_slot(input logic sw, input logic [31:0] d, input int nb,
                             input bit push, input logic [15:0] el, input logic [15:0] er);
        for (int i = nb - 1; i >= 0; i--)
            send_bit((i == 0) ? ~sw : sw, d[i], push && (i == 0), el, er);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit push);
        send_slot(1'b0, {16'h0, l}, 16, 1'b0, 16'h0, 16'h0);
        send_slot(1'b1, {16'h0, r}, 16, push, l, r);
    endtask

    // Scoreboard consumer: every valid pulse must match the head of the queue.
    always begin
        @(posedge clk);
        #1;
        if (err_o === 1'b1) err_cnt++;
        if (valid_o === 1'b1) begin
            exp_t e;
            vcnt++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("left", 32'(left_o), 32'(e.l));
                chk("right", 32'(right_o), 32'(e.r));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        int e0, t;
        rst_n = 1'b0; bck = 1'b0; ws = 1'b0; din = 1'b0;
        @(negedge clk);

        // Reset held against a live stream.
        send_frame(16'h8001, 16'h7FFE, 1'b0);
        chk("rst_left", 32'(left_o), 0);
        chk("rst_right", 32'(right_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_locked", 32'(locked_o), 0);

        // Release: hunt slot and orphan right slot yield nothing.
        rst_n = 1'b1;
        send_frame(16'h8001, 16'h7FFE, 1'b0);
        chk("hunt_no_valid", vcnt, 0);
        chk("hunt_locked", 32'(locked_o), 0);
        repeat (3) send_frame(16'h8001, 16'h7FFE, 1'b1);
        chk("basic_locked", 32'(locked_o), 1);
        chk("basic_vcnt", vcnt, 3);

        // 32-bit slots: only the first 16 bits are kept.
        e0 = err_cnt;
        send_slot(1'b0, {16'h1234, 16'hFFFF}, 32, 1'b0, 16'h0, 16'h0);
        send_slot(1'b1, {16'hABCD, 16'h0000}, 32, 1'b1, 16'h1234, 16'hABCD);
        chk("s32_no_err", err_cnt, e0);
        chk("s32_locked", 32'(locked_o), 1);

        // Short left slot: one error, lock lost, right slot discarded.
        send_slot(1'b0, 32'h0000_1234, 15, 1'b0, 16'h0, 16'h0);
        chk("short_err", err_cnt, e0 + 1);
        chk("short_locked", 32'(locked_o), 0);
        send_slot(1'b1, 32'h0000_5555, 16, 1'b0, 16'h0, 16'h0);
        chk("short_no_valid", vcnt, 4);
        send_frame(16'h0F0F, 16'hF0F0, 1'b1);
        chk("recover_locked", 32'(locked_o), 1);
        chk("recover_err", err_cnt, e0 + 1);

        // Timeout: lock falls exactly TIMEOUT cycles after the last rise is processed.
        t = last_t0 + 3 + 1023;
        do begin @(posedge clk); #1; end while (cyc < t);
        chk("to_before", 32'(locked_o), 1);
        @(posedge clk); #1;
        chk("to_after", 32'(locked_o), 0);
        repeat (80) @(negedge clk);
        send_frame(16'h1111, 16'h2222, 1'b0);
        chk("to_hold_left", 32'(left_o), 32'h0F0F);
        chk("to_hold_right", 32'(right_o), 32'hF0F0);
        chk("to_hunt_locked", 32'(locked_o), 0);
        send_frame(16'h5A5A, 16'hA5A5, 1'b1);
        chk("to_relock", 32'(locked_o), 1);

        // Reset after 8 bits of a left slot.
        for (int i = 15; i >= 8; i--) send_bit(1'b0, i[0], 1'b0, 16'h0, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_left", 32'(left_o), 0);
        chk("mid_right", 32'(right_o), 0);
        chk("mid_locked", 32'(locked_o), 0);
        chk("mid_valid", 32'(valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit((i == 0), i[0], 1'b0, 16'h0, 16'h0);
        send_slot(1'b1, 32'h0000_3C3C, 16, 1'b0, 16'h0, 16'h0);
        chk("mid_no_valid", vcnt, 6);
        send_frame(16'hC001, 16'h0C0D, 1'b1);

        repeat (20) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        chk("valid_total", vcnt, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
